axi4_lite_arbiter: RTL and testbench

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

---
 rtl/axi4_lite_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter in front of a single slave.
// Independent write and read FSMs with separate round-robin pointers.
module axi4_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    m0_AWVALID,
    output logic                    m0_AWREADY,
    input  logic [2:0]              m0_AWPROT,
    input  logic [ADDR_WIDTH-1:0]   m0_AWADDR,
    input  logic                    m0_WVALID,
    output logic                    m0_WREADY,
    input  logic [DATA_WIDTH/8-1:0] m0_WSTRB,
    input  logic [DATA_WIDTH-1:0]   m0_WDATA,
    input  logic                    m0_BREADY,
    output logic                    m0_BVALID,
    output logic [1:0]              m0_BRESP,
    input  logic                    m0_ARVALID,
    output logic                    m0_ARREADY,
    input  logic [2:0]              m0_ARPROT,
    input  logic [ADDR_WIDTH-1:0]   m0_ARADDR,
    input  logic                    m0_RREADY,
    output logic                    m0_RVALID,
    output logic [1:0]              m0_RRESP,
    output logic [DATA_WIDTH-1:0]   m0_RDATA,
    input  logic                    m1_AWVALID,
    output logic                    m1_AWREADY,
    input  logic [2:0]              m1_AWPROT,
    input  logic [ADDR_WIDTH-1:0]   m1_AWADDR,
    input  logic                    m1_WVALID,
    output logic                    m1_WREADY,
    input  logic [DATA_WIDTH/8-1:0] m1_WSTRB,
    input  logic [DATA_WIDTH-1:0]   m1_WDATA,
    input  logic                    m1_BREADY,
    output logic                    m1_BVALID,
    output logic [1:0]              m1_BRESP,
    input  logic                    m1_ARVALID,
    output logic                    m1_ARREADY,
    input  logic [2:0]              m1_ARPROT,
    input  logic [ADDR_WIDTH-1:0]   m1_ARADDR,
    input  logic                    m1_RREADY,
    output logic                    m1_RVALID,
    output logic [1:0]              m1_RRESP,
    output logic [DATA_WIDTH-1:0]   m1_RDATA,
    output logic                    s_AWVALID,
    input  logic                    s_AWREADY,
    output logic [2:0]              s_AWPROT,
    output logic [ADDR_WIDTH-1:0]   s_AWADDR,
    output logic                    s_WVALID,
    input  logic                    s_WREADY,
    output logic [DATA_WIDTH/8-1:0] s_WSTRB,
    output logic [DATA_WIDTH-1:0]   s_WDATA,
    output logic                    s_BREADY,
    input  logic                    s_BVALID,
    input  logic [1:0]              s_BRESP,
    output logic                    s_ARVALID,
    input  logic                    s_ARREADY,
    output logic [2:0]              s_ARPROT,
    output logic [ADDR_WIDTH-1:0]   s_ARADDR,
    output logic                    s_RREADY,
    input  logic                    s_RVALID,
    input  logic [1:0]              s_RRESP,
    input  logic [DATA_WIDTH-1:0]   s_RDATA
);
    localparam int SW = DATA_WIDTH / 8;

    typedef struct packed {
        logic [2:0]            prot;
        logic [ADDR_WIDTH-1:0] addr;
    } ax_t;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    // Requester-indexed views of the two upstream ports
    logic [1:0]                 aw_valid, w_valid, b_ready, ar_valid, r_ready;
    ax_t  [1:0]                 aw_req, ar_req;
    logic [1:0][SW-1:0]         w_strb;
    logic [1:0][DATA_WIDTH-1:0] w_data, r_data;
    logic [1:0]                 aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0][1:0]            b_resp, r_resp;

    assign aw_valid  = {m1_AWVALID, m0_AWVALID};
    assign w_valid   = {m1_WVALID,  m0_WVALID};
    assign b_ready   = {m1_BREADY,  m0_BREADY};
    assign ar_valid  = {m1_ARVALID, m0_ARVALID};
    assign r_ready   = {m1_RREADY,  m0_RREADY};
    assign aw_req[0] = {m0_AWPROT, m0_AWADDR};
    assign aw_req[1] = {m1_AWPROT, m1_AWADDR};
    assign ar_req[0] = {m0_ARPROT, m0_ARADDR};
    assign ar_req[1] = {m1_ARPROT, m1_ARADDR};
    assign w_strb    = {m1_WSTRB, m0_WSTRB};
    assign w_data    = {m1_WDATA, m0_WDATA};

    assign {m1_AWREADY, m0_AWREADY} = aw_ready;
    assign {m1_WREADY,  m0_WREADY}  = w_ready;
    assign {m1_BVALID,  m0_BVALID}  = b_valid;
    assign {m1_BRESP,   m0_BRESP}   = b_resp;
    assign {m1_ARREADY, m0_ARREADY} = ar_ready;
    assign {m1_RVALID,  m0_RVALID}  = r_valid;
    assign {m1_RRESP,   m0_RRESP}   = r_resp;
    assign {m1_RDATA,   m0_RDATA}   = r_data;

    // Contention goes to whoever did not win last; a lone requester always wins
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        return (&req) ? ~last : req[1];
    endfunction

    // ---------------- write path ----------------
    w_state_t w_state, w_state_nxt;
    logic     w_gnt, w_last, aw_done, w_done, aw_hs, w_hs;

    assign aw_hs = s_AWVALID & s_AWREADY;
    assign w_hs  = s_WVALID & s_WREADY;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            w_state <= W_IDLE;
            w_gnt   <= 1'b0;
            w_last  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (w_state == W_IDLE && |aw_valid) begin
                w_gnt   <= rr_pick(aw_valid, w_last);
                w_last  <= rr_pick(aw_valid, w_last);
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_ADDR) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (|aw_valid) w_state_nxt = W_ADDR;
            W_ADDR:  if ((aw_done | aw_hs) && (w_done | w_hs)) w_state_nxt = W_RESP;
            W_RESP:  if (s_BVALID && b_ready[w_gnt]) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_AWVALID = 1'b0;
        s_AWPROT  = '0;
        s_AWADDR  = '0;
        s_WVALID  = 1'b0;
        s_WSTRB   = '0;
        s_WDATA   = '0;
        s_BREADY  = 1'b0;
        aw_ready  = '0;
        w_ready   = '0;
        b_valid   = '0;
        b_resp    = '0;
        case (w_state)
            W_ADDR: begin
                s_AWVALID       = aw_valid[w_gnt] & ~aw_done;
                s_AWPROT        = aw_req[w_gnt].prot;
                s_AWADDR        = aw_req[w_gnt].addr;
                s_WVALID        = w_valid[w_gnt] & ~w_done;
                s_WSTRB         = w_strb[w_gnt];
                s_WDATA         = w_data[w_gnt];
                aw_ready[w_gnt] = s_AWREADY & ~aw_done;
                w_ready[w_gnt]  = s_WREADY & ~w_done;
            end
            W_RESP: begin
                s_BREADY       = b_ready[w_gnt];
                b_valid[w_gnt] = s_BVALID;
                b_resp[w_gnt]  = s_BRESP;
            end
            default: ;
        endcase
    end

    // ---------------- read path ----------------
    r_state_t r_state, r_state_nxt;
    logic     r_gnt, r_last;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= R_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && |ar_valid) begin
                r_gnt  <= rr_pick(ar_valid, r_last);
                r_last <= rr_pick(ar_valid, r_last);
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (|ar_valid) r_state_nxt = R_ADDR;
            R_ADDR:  if (s_ARVALID && s_ARREADY) r_state_nxt = R_DATA;
            R_DATA:  if (s_RVALID && r_ready[r_gnt]) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_ARVALID = 1'b0;
        s_ARPROT  = '0;
        s_ARADDR  = '0;
        s_RREADY  = 1'b0;
        ar_ready  = '0;
        r_valid   = '0;
        r_resp    = '0;
        r_data    = '0;
        case (r_state)
            R_ADDR: begin
                s_ARVALID       = ar_valid[r_gnt];
                s_ARPROT        = ar_req[r_gnt].prot;
                s_ARADDR        = ar_req[r_gnt].addr;
                ar_ready[r_gnt] = s_ARREADY;
            end
            R_DATA: begin
                s_RREADY       = r_ready[r_gnt];
                r_valid[r_gnt] = s_RVALID;
                r_resp[r_gnt]  = s_RRESP;
                r_data[r_gnt]  = s_RDATA;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench: two requester drivers, a memory-backed slave model with
// programmable ready/response latency, and handshake monitors.
module tb_axi4_lite_arbiter;
    logic iCLK = 1'b0, iRST;
    always #5 iCLK = ~iCLK;

    logic [1:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [2:0]  m_awprot [2], m_arprot [2];
    logic [31:0] m_awaddr [2], m_wdata [2], m_araddr [2];
    logic [3:0]  m_wstrb [2];

    logic m0_AWREADY, m0_WREADY, m0_BVALID, m0_ARREADY, m0_RVALID;
    logic m1_AWREADY, m1_WREADY, m1_BVALID, m1_ARREADY, m1_RVALID;
    logic [1:0] m0_BRESP, m0_RRESP, m1_BRESP, m1_RRESP;
    logic [31:0] m0_RDATA, m1_RDATA;
    logic s_AWVALID, s_WVALID, s_BREADY, s_ARVALID, s_RREADY;
    logic [2:0] s_AWPROT, s_ARPROT;
    logic [31:0] s_AWADDR, s_WDATA, s_ARADDR;
    logic [3:0] s_WSTRB;
    logic s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RVALID;
    logic [1:0] s_BRESP, s_RRESP;
    logic [31:0] s_RDATA;

    axi4_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .m0_AWVALID(m_awvalid[0]), .m0_AWREADY(m0_AWREADY), .m0_AWPROT(m_awprot[0]), .m0_AWADDR(m_awaddr[0]),
        .m0_WVALID(m_wvalid[0]), .m0_WREADY(m0_WREADY), .m0_WSTRB(m_wstrb[0]), .m0_WDATA(m_wdata[0]),
        .m0_BREADY(m_bready[0]), .m0_BVALID(m0_BVALID), .m0_BRESP(m0_BRESP),
        .m0_ARVALID(m_arvalid[0]), .m0_ARREADY(m0_ARREADY), .m0_ARPROT(m_arprot[0]), .m0_ARADDR(m_araddr[0]),
        .m0_RREADY(m_rready[0]), .m0_RVALID(m0_RVALID), .m0_RRESP(m0_RRESP), .m0_RDATA(m0_RDATA),
        .m1_AWVALID(m_awvalid[1]), .m1_AWREADY(m1_AWREADY), .m1_AWPROT(m_awprot[1]), .m1_AWADDR(m_awaddr[1]),
        .m1_WVALID(m_wvalid[1]), .m1_WREADY(m1_WREADY), .m1_WSTRB(m_wstrb[1]), .m1_WDATA(m_wdata[1]),
        .m1_BREADY(m_bready[1]), .m1_BVALID(m1_BVALID), .m1_BRESP(m1_BRESP),
        .m1_ARVALID(m_arvalid[1]), .m1_ARREADY(m1_ARREADY), .m1_ARPROT(m_arprot[1]), .m1_ARADDR(m_araddr[1]),
        .m1_RREADY(m_rready[1]), .m1_RVALID(m1_RVALID), .m1_RRESP(m1_RRESP), .m1_RDATA(m1_RDATA),
        .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWPROT(s_AWPROT), .s_AWADDR(s_AWADDR),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WSTRB(s_WSTRB), .s_WDATA(s_WDATA),
        .s_BREADY(s_BREADY), .s_BVALID(s_BVALID), .s_BRESP(s_BRESP),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARPROT(s_ARPROT), .s_ARADDR(s_ARADDR),
        .s_RREADY(s_RREADY), .s_RVALID(s_RVALID), .s_RRESP(s_RRESP), .s_RDATA(s_RDATA)
    );

    // Per-requester views for the driver tasks
    logic [1:0] aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic [1:0] b_rsp [2], r_rsp [2];
    logic [31:0] r_dat [2];
    assign aw_rdy = {m1_AWREADY, m0_AWREADY};
    assign w_rdy  = {m1_WREADY, m0_WREADY};
    assign b_vld  = {m1_BVALID, m0_BVALID};
    assign ar_rdy = {m1_ARREADY, m0_ARREADY};
    assign r_vld  = {m1_RVALID, m0_RVALID};
    assign b_rsp[0] = m0_BRESP;
    assign b_rsp[1] = m1_BRESP;
    assign r_rsp[0] = m0_RRESP;
    assign r_rsp[1] = m1_RRESP;
    assign r_dat[0] = m0_RDATA;
    assign r_dat[1] = m1_RDATA;

    logic all_any, m1_any;
    assign m1_any = m1_AWREADY | m1_WREADY | m1_BVALID | m1_ARREADY | m1_RVALID
                  | (|m1_BRESP) | (|m1_RRESP) | (|m1_RDATA);
    assign all_any = m1_any | m0_AWREADY | m0_WREADY | m0_BVALID | m0_ARREADY | m0_RVALID
                   | (|m0_BRESP) | (|m0_RRESP) | (|m0_RDATA)
                   | (|{s_AWVALID, s_AWPROT, s_AWADDR, s_WVALID, s_WSTRB, s_WDATA, s_BREADY})
                   | (|{s_ARVALID, s_ARPROT, s_ARADDR, s_RREADY});

    // Slave model: READY after *_lat cycles of VALID, SLVERR for addr[7]=1
    logic [31:0] mem [0:255] = '{default: 32'h0};
    int aw_lat = 0, w_lat = 0, r_lat = 0;
    int aw_cnt, w_cnt, r_cnt, wr_cnt = 0;
    logic aw_got, w_got, ar_got;
    logic [31:0] sa_addr, sw_data, sr_addr;
    logic [3:0] sw_strb;

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s_AWREADY <= 0; s_WREADY <= 0; s_BVALID <= 0; s_BRESP <= 0;
            s_ARREADY <= 0; s_RVALID <= 0; s_RRESP <= 0; s_RDATA <= 0;
            aw_got <= 0; w_got <= 0; ar_got <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
        end else begin
            if (s_AWVALID && s_AWREADY) begin
                s_AWREADY <= 0; aw_got <= 1; sa_addr <= s_AWADDR;
            end else if (s_AWVALID && !aw_got) begin
                if (aw_cnt >= aw_lat) s_AWREADY <= 1; else aw_cnt <= aw_cnt + 1;
            end
            if (s_WVALID && s_WREADY) begin
                s_WREADY <= 0; w_got <= 1; sw_data <= s_WDATA; sw_strb <= s_WSTRB;
            end else if (s_WVALID && !w_got) begin
                if (w_cnt >= w_lat) s_WREADY <= 1; else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !s_BVALID) begin
                for (int b = 0; b < 4; b++)
                    if (sw_strb[b]) mem[sa_addr[7:0]][8*b +: 8] <= sw_data[8*b +: 8];
                wr_cnt <= wr_cnt + 1;
                s_BVALID <= 1;
                s_BRESP <= sa_addr[7] ? 2'b10 : 2'b00;
            end else if (s_BVALID && s_BREADY) begin
                s_BVALID <= 0; aw_got <= 0; w_got <= 0; aw_cnt <= 0; w_cnt <= 0;
            end
            if (s_ARVALID && s_ARREADY) begin
                s_ARREADY <= 0; ar_got <= 1; sr_addr <= s_ARADDR; r_cnt <= 0;
            end else if (s_ARVALID && !ar_got) begin
                s_ARREADY <= 1;
            end
            if (ar_got && !s_RVALID) begin
                if (r_cnt >= r_lat) begin
                    s_RVALID <= 1; s_RDATA <= mem[sr_addr[7:0]];
                    s_RRESP <= sr_addr[7] ? 2'b10 : 2'b00;
                end else r_cnt <= r_cnt + 1;
            end else if (s_RVALID && s_RREADY) begin
                s_RVALID <= 0; ar_got <= 0;
            end
        end
    end

    // Monitors
    int cyc = 0, aw_hs_cnt = 0, w_hs_cnt = 0, wv_after = 0, both_act = 0, xroute = 0, m1_act = 0;
    int aw_cyc = 0, w_cyc = 0;
    logic mon_wd = 1'b0;
    int wr_order [$];

    always @(posedge iCLK) begin
        cyc <= cyc + 1;
        if (s_AWVALID && s_AWREADY) begin aw_hs_cnt <= aw_hs_cnt + 1; aw_cyc <= cyc; end
        if (s_WVALID && s_WREADY) begin w_hs_cnt <= w_hs_cnt + 1; w_cyc <= cyc; end
        if (iRST || (s_BVALID && s_BREADY)) mon_wd <= 1'b0;
        else if (s_WVALID && s_WREADY) mon_wd <= 1'b1;
        if (s_WVALID && mon_wd) wv_after <= wv_after + 1;
        if (s_AWVALID && s_ARVALID) both_act <= both_act + 1;
        if (m0_RVALID || m0_ARREADY || m1_BVALID || m1_AWREADY || m1_WREADY) xroute <= xroute + 1;
        if (m1_any) m1_act <= m1_act + 1;
        if (m_awvalid[0] && m0_AWREADY) wr_order.push_back(0);
        if (m_awvalid[1] && m1_AWREADY) wr_order.push_back(1);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, output logic [1:0] resp);
        bit aw_ok = 0, w_ok = 0, b_ok = 0;
        int t = 0;
        m_awaddr[k] = a; m_wdata[k] = d; m_wstrb[k] = st;
        m_awvalid[k] = 1'b1; m_wvalid[k] = 1'b1;
        while (!(aw_ok && w_ok) && t < 100) begin
            bit ha, hw;
            ha = m_awvalid[k] && aw_rdy[k];
            hw = m_wvalid[k] && w_rdy[k];
            @(posedge iCLK); #1; t++;
            if (ha) begin m_awvalid[k] = 1'b0; aw_ok = 1; end
            if (hw) begin m_wvalid[k] = 1'b0; w_ok = 1; end
        end
        m_awvalid[k] = 1'b0; m_wvalid[k] = 1'b0;
        chk($sformatf("wr%0d_addr_data_handshake", k), {aw_ok, w_ok}, 2'b11);
        resp = 2'b11; t = 0;
        m_bready[k] = 1'b1;
        while (!b_ok && t < 100) begin
            if (b_vld[k]) begin resp = b_rsp[k]; b_ok = 1; end
            @(posedge iCLK); #1; t++;
        end
        m_bready[k] = 1'b0;
        chk($sformatf("wr%0d_bresp_seen", k), b_ok, 1);
    endtask

    task automatic do_read(input int k, input logic [31:0] a,
                           output logic [31:0] data, output logic [1:0] resp);
        bit ar_ok = 0, r_ok = 0;
        int t = 0;
        m_araddr[k] = a; m_arvalid[k] = 1'b1;
        while (!ar_ok && t < 100) begin
            if (ar_rdy[k]) ar_ok = 1;
            @(posedge iCLK); #1; t++;
        end
        m_arvalid[k] = 1'b0;
        chk($sformatf("rd%0d_addr_handshake", k), ar_ok, 1);
        data = 32'hx; resp = 2'b11; t = 0;
        m_rready[k] = 1'b1;
        while (!r_ok && t < 100) begin
            if (r_vld[k]) begin data = r_dat[k]; resp = r_rsp[k]; r_ok = 1; end
            @(posedge iCLK); #1; t++;
        end
        m_rready[k] = 1'b0;
        chk($sformatf("rd%0d_rvalid_seen", k), r_ok, 1);
    endtask

    typedef struct {
        bit          rd;
        int          k;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp_val;   // read data, or memory word after a write
    } vec_t;

    vec_t tv [8];
    logic [1:0]  r0, r1, rr;
    logic [31:0] rd;
    int qs, s_aw, s_w, s_wv, s_wr, s_ba, s_xr, s_m1;
    bit ok;

    initial begin
        tv[0] = '{0, 1, 32'h10, 32'hCAFE0010, 4'hF, 2'b00, 32'hCAFE0010};
        tv[1] = '{1, 0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hCAFE0010};
        tv[2] = '{0, 0, 32'h10, 32'h12345678, 4'h3, 2'b00, 32'hCAFE5678};
        tv[3] = '{1, 1, 32'h10, 32'h0,        4'h0, 2'b00, 32'hCAFE5678};
        tv[4] = '{0, 1, 32'h84, 32'h0000DEAD, 4'hF, 2'b10, 32'h0000DEAD};
        tv[5] = '{1, 0, 32'h84, 32'h0,        4'h0, 2'b10, 32'h0000DEAD};
        tv[6] = '{1, 1, 32'h20, 32'h0,        4'h0, 2'b00, 32'h00001F90};
        tv[7] = '{0, 0, 32'h30, 32'hA5A5A5A5, 4'h8, 2'b00, 32'hA5000000};

        iRST = 1'b1;
        m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
        for (int i = 0; i < 2; i++) begin
            m_awprot[i] = 3'(i + 1); m_arprot[i] = 3'(i + 4);
            m_awaddr[i] = 0; m_wdata[i] = 0; m_araddr[i] = 0; m_wstrb[i] = 0;
        end
        #3;
        chk("reset_outputs_zero", all_any, 1'b0);
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
        @(posedge iCLK); #1;

        // Lone m0 write: AW forwarded one cycle after the request, m1 untouched
        s_m1 = m1_act;
        fork
            do_write(0, 32'h20, 32'h1F90, 4'hF, r0);
            begin
                @(posedge iCLK); #1;
                chk("aw_forward_latency", {s_AWVALID, s_AWPROT, s_AWADDR}, {1'b1, 3'd1, 32'h20});
            end
        join
        chk("single_write_mem", mem[8'h20], 32'h1F90);
        chk("single_write_bresp", r0, 2'b00);
        chk("single_write_m1_quiet", m1_act - s_m1, 0);

        for (int i = 0; i < 8; i++) begin
            if (tv[i].rd) begin
                do_read(tv[i].k, tv[i].addr, rd, rr);
                chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_val);
            end else begin
                do_write(tv[i].k, tv[i].addr, tv[i].data, tv[i].strb, rr);
                chk($sformatf("vec%0d_mem", i), mem[tv[i].addr[7:0]], tv[i].exp_val);
            end
            chk($sformatf("vec%0d_resp", i), rr, tv[i].resp);
        end

        // Contention right after reset: m0 first, then alternating
        @(posedge iCLK); #1 iRST = 1'b1;
        @(posedge iCLK); #1 iRST = 1'b0;
        qs = wr_order.size();
        fork
            do_write(0, 32'h20, 32'h1111, 4'hF, r0);
            do_write(1, 32'h0F, 32'h2222, 4'hF, r1);
        join
        fork
            do_write(0, 32'h20, 32'h3333, 4'hF, r0);
            do_write(1, 32'h0F, 32'h4444, 4'hF, r1);
        join
        chk("rr_order_count", wr_order.size() - qs, 4);
        for (int i = 0; i < 4; i++)
            if (qs + i < wr_order.size())
                chk($sformatf("rr_order_%0d", i), wr_order[qs + i], i % 2);
        chk("rr_mem_m0", mem[8'h20], 32'h3333);
        chk("rr_mem_m1", mem[8'h0F], 32'h4444);

        // Concurrent write (m0) and read (m1)
        s_ba = both_act; s_xr = xroute;
        fork
            do_write(0, 32'h20, 32'h5555, 4'hF, r0);
            do_read(1, 32'h10, rd, rr);
        join
        chk("concurrent_rdata", rd, 32'hCAFE5678);
        chk("concurrent_rresp", rr, 2'b00);
        chk("concurrent_overlap", both_act > s_ba, 1);
        chk("concurrent_no_crossroute", xroute - s_xr, 0);
        chk("concurrent_mem", mem[8'h20], 32'h5555);

        // Slave takes W two cycles ahead of AW
        aw_lat = 2; w_lat = 0;
        s_aw = aw_hs_cnt; s_w = w_hs_cnt; s_wv = wv_after; s_wr = wr_cnt;
        do_write(0, 32'h24, 32'h6666, 4'hF, r0);
        chk("w_early_aw_hs_count", aw_hs_cnt - s_aw, 1);
        chk("w_early_w_hs_count", w_hs_cnt - s_w, 1);
        chk("w_early_gap", aw_cyc - w_cyc, 2);
        chk("w_early_wvalid_dropped", wv_after - s_wv, 0);
        chk("w_early_single_write", wr_cnt - s_wr, 1);
        chk("w_early_mem", mem[8'h24], 32'h6666);
        chk("w_early_bresp", r0, 2'b00);
        aw_lat = 0;

        // Reset during a stalled read data phase
        r_lat = 1000;
        m_araddr[1] = 32'h20; m_arvalid[1] = 1'b1; ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (ar_rdy[1]) ok = 1;
            @(posedge iCLK); #1;
        end
        m_arvalid[1] = 1'b0;
        chk("stall_ar_handshake", ok, 1);
        m_rready[1] = 1'b1;
        repeat (3) begin @(posedge iCLK); #1; end
        chk("stall_in_rdata", s_RREADY, 1);
        @(negedge iCLK); iRST = 1'b1; #1;
        chk("async_reset_outputs_zero", all_any, 1'b0);
        @(posedge iCLK); #1;
        iRST = 1'b0; m_rready[1] = 1'b0; r_lat = 0;
        @(posedge iCLK); #1;
        do_read(1, 32'h20, rd, rr);
        chk("post_reset_rdata", rd, 32'h5555);
        chk("post_reset_rresp", rr, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "global timeout");
    end
endmodule
